song_reader: RTL and testbench

//   Player-side partner of the mcu: consumes play, reset_player and song[1:0],

---
 rtl/song_reader.sv | 135 +++++++++++++
 tb/tb_song_reader.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/song_reader.sv
// song_reader: walks the selected song's note ROM and hands one note at a time
// to the note player, pulsing song_done back to the mcu when the song ends.
module song_reader #(
    parameter int NOTE_W = 6,
    parameter int DUR_W  = 6,
    parameter int IDX_W  = 5
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    play,
    input  logic                    reset_player,
    input  logic [1:0]              song,
    input  logic                    note_done,
    output logic [IDX_W+1:0]        rom_addr,
    input  logic [NOTE_W+DUR_W-1:0] rom_data,
    output logic [NOTE_W-1:0]       note,
    output logic [DUR_W-1:0]        duration,
    output logic                    new_note,
    output logic                    song_done
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LATCH,
        WAIT,
        DONE
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = {IDX_W{1'b1}};
    localparam logic [IDX_W-1:0] IDX_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};

    state_t             state;
    state_t             state_n;
    logic [IDX_W-1:0]   idx;
    logic [IDX_W-1:0]   idx_n;
    logic [1:0]         song_q;
    logic [1:0]         song_q_n;
    logic [NOTE_W-1:0]  note_n;
    logic [DUR_W-1:0]   duration_n;
    logic               new_note_n;
    logic               song_done_n;

    logic [NOTE_W-1:0]  rom_note;
    logic [DUR_W-1:0]   rom_dur;

    assign rom_note = rom_data[NOTE_W+DUR_W-1:DUR_W];
    assign rom_dur  = rom_data[DUR_W-1:0];

    // The page bits come from the latched song, so idx can never spill into the next song.
    assign rom_addr = {song_q, idx};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            idx       <= '0;
            song_q    <= '0;
            note      <= '0;
            duration  <= '0;
            new_note  <= 1'b0;
            song_done <= 1'b0;
        end else begin
            state     <= state_n;
            idx       <= idx_n;
            song_q    <= song_q_n;
            note      <= note_n;
            duration  <= duration_n;
            new_note  <= new_note_n;
            song_done <= song_done_n;
        end
    end

    always_comb begin
        state_n     = state;
        idx_n       = idx;
        song_q_n    = song_q;
        note_n      = note;
        duration_n  = duration;
        new_note_n  = 1'b0;
        song_done_n = 1'b0;

        if (reset_player) begin
            state_n    = IDLE;
            idx_n      = '0;
            song_q_n   = song;
            note_n     = '0;
            duration_n = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (play) begin
                        song_q_n = song;
                        state_n  = FETCH;
                    end
                end
                FETCH: begin
                    if (play) begin
                        state_n = LATCH;
                    end
                end
                LATCH: begin
                    // A zero duration marks the end of the song; the last note stays on the outputs.
                    if (rom_dur == '0) begin
                        state_n     = DONE;
                        song_done_n = 1'b1;
                    end else begin
                        note_n     = rom_note;
                        duration_n = rom_dur;
                        new_note_n = 1'b1;
                        state_n    = WAIT;
                    end
                end
                WAIT: begin
                    // The note player may finish while paused, so play is not consulted here.
                    if (note_done) begin
                        if (idx == LAST_IDX) begin
                            state_n     = DONE;
                            song_done_n = 1'b1;
                        end else begin
                            idx_n   = idx + IDX_ONE;
                            state_n = FETCH;
                        end
                    end
                end
                DONE: begin
                    state_n = DONE;
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_song_reader.sv
// tb_song_reader: directed vector table for the documented scenarios plus randomized
// whole-song runs scored against a note list derived straight from the ROM contents.
module tb_song_reader;

    logic        clk;
    logic        reset;
    logic        play;
    logic        reset_player;
    logic [1:0]  song;
    logic        note_done;
    logic [6:0]  rom_addr;
    logic [11:0] rom_data;
    logic [5:0]  note;
    logic [5:0]  duration;
    logic        new_note;
    logic        song_done;

    logic [11:0] rom [0:127];

    int total_cnt;
    int bad_cnt;

    typedef struct packed {
        logic       play;
        logic       note_done;
        logic       reset_player;
        logic [1:0] song;
        logic [6:0] addr;
        logic       nn;
        logic [5:0] note;
        logic [5:0] dur;
        logic       sd;
    } vec_t;

    vec_t vq[$];

    song_reader dut (
        .clk          (clk),
        .reset        (reset),
        .play         (play),
        .reset_player (reset_player),
        .song         (song),
        .note_done    (note_done),
        .rom_addr     (rom_addr),
        .rom_data     (rom_data),
        .note         (note),
        .duration     (duration),
        .new_note     (new_note),
        .song_done    (song_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous song ROM: data appears one cycle after the address.
    always @(posedge clk) rom_data <= rom[rom_addr];

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) begin
            bad_cnt++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs and return at the following negedge.
    task automatic applyStimulus(input logic p, input logic nd, input logic rp, input logic [1:0] s);
        play         = p;
        note_done    = nd;
        reset_player = rp;
        song         = s;
        @(negedge clk);
    endtask

    task automatic addV(input logic p, input logic nd, input logic rp, input logic [1:0] s,
                        input logic [6:0] a, input logic n, input logic [5:0] nt,
                        input logic [5:0] d, input logic sd);
        vec_t v;
        v.play = p; v.note_done = nd; v.reset_player = rp; v.song = s;
        v.addr = a; v.nn = n; v.note = nt; v.dur = d; v.sd = sd;
        vq.push_back(v);
    endtask

    task automatic runSong(input logic [1:0] s, input int term);
        logic [11:0] exp_q[$];
        logic [11:0] last_val;
        int          got;
        int          done_cnt;
        int          pending;
        int          tail;
        logic        page_ok;
        logic        nd;
        logic [5:0]  n;
        logic [5:0]  d;
        got = 0; done_cnt = 0; pending = -1; tail = -1; page_ok = 1'b1;
        for (int i = 0; i < 32; i++) begin
            n = 6'($urandom_range(1, 63));
            d = (i == term) ? 6'd0 : 6'($urandom_range(1, 63));
            rom[{s, 5'(i)}] = {n, d};
        end
        // Expected notes: every entry up to (not including) the first zero duration.
        for (int i = 0; i < 32; i++) begin
            if (rom[{s, 5'(i)}][5:0] == 6'd0) break;
            exp_q.push_back(rom[{s, 5'(i)}]);
        end
        last_val = (exp_q.size() == 0) ? 12'd0 : exp_q[exp_q.size()-1];
        applyStimulus(1'b0, 1'b0, 1'b1, s);
        for (int cyc = 0; cyc < 3000 && tail != 0; cyc++) begin
            if (rom_addr[6:5] != s) page_ok = 1'b0;
            if (new_note) begin
                if (got < exp_q.size())
                    checkOutput("rand_note", {20'd0, note, duration}, {20'd0, exp_q[got]});
                else
                    checkOutput("rand_extra_note", 32'd1, 32'd0);
                got++;
                pending = $urandom_range(0, 4);
            end
            if (song_done) begin
                done_cnt++;
                if (tail < 0) tail = 12;
            end
            if (tail > 0) tail--;
            nd = 1'b0;
            if (pending == 0) begin
                nd = 1'b1;
                pending = -1;
            end else if (pending > 0) begin
                pending--;
            end
            if (tail >= 0) nd = 1'($urandom_range(0, 1));
            applyStimulus(($urandom_range(0, 3) != 0), nd, 1'b0, s);
        end
        checkOutput("rand_count", got, exp_q.size());
        checkOutput("rand_done_cnt", done_cnt, 32'd1);
        checkOutput("rand_page", {31'd0, page_ok}, 32'd1);
        checkOutput("rand_hold", {20'd0, note, duration}, {20'd0, last_val});
    endtask

    task automatic waitNewNote(input string name);
        int k;
        k = 0;
        while (!new_note && k < 12) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 2'd0);
            k++;
        end
        checkOutput(name, {31'd0, new_note}, 32'd1);
    endtask

    initial begin
        total_cnt = 0;
        bad_cnt   = 0;
        reset = 1'b1; play = 1'b0; reset_player = 1'b0; song = 2'd2; note_done = 1'b0;
        for (int i = 0; i < 128; i++) rom[i] = 12'd0;
        rom[64] = {6'd20, 6'd8};
        rom[65] = {6'd22, 6'd4};
        rom[66] = {6'd25, 6'd3};
        rom[67] = {6'd30, 6'd0};
        rom[32] = {6'd5,  6'd7};

        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        checkOutput("reset_addr", {25'd0, rom_addr}, 32'd0);
        checkOutput("reset_note", {26'd0, note}, 32'd0);
        checkOutput("reset_dur", {26'd0, duration}, 32'd0);
        checkOutput("reset_nn", {31'd0, new_note}, 32'd0);
        checkOutput("reset_sd", {31'd0, song_done}, 32'd0);

        // play, nd, rp, song | addr, nn, note, dur, sd
        addV(1,0,0,2, 64,0, 0,0,0);
        addV(1,0,0,2, 64,0, 0,0,0);
        addV(1,0,0,2, 64,1,20,8,0);
        addV(1,0,0,2, 64,0,20,8,0);
        addV(1,1,0,2, 65,0,20,8,0);
        addV(1,0,0,2, 65,0,20,8,0);
        addV(1,1,0,2, 65,1,22,4,0);
        addV(1,0,0,2, 65,0,22,4,0);
        addV(1,1,0,2, 66,0,22,4,0);
        addV(1,0,0,2, 66,0,22,4,0);
        addV(1,0,0,2, 66,1,25,3,0);
        addV(1,1,0,2, 67,0,25,3,0);
        addV(1,0,0,2, 67,0,25,3,0);
        addV(1,0,0,2, 67,0,25,3,1);
        addV(1,0,0,2, 67,0,25,3,0);
        addV(1,1,0,2, 67,0,25,3,0);
        addV(0,1,0,3, 67,0,25,3,0);
        addV(1,0,1,2, 64,0, 0,0,0);
        addV(1,0,0,2, 64,0, 0,0,0);
        for (int i = 0; i < 5; i++) addV(0,0,0,2, 64,0,0,0,0);
        addV(1,0,0,2, 64,0, 0,0,0);
        addV(1,0,0,2, 64,1,20,8,0);
        addV(0,1,0,2, 65,0,20,8,0);
        addV(0,0,0,2, 65,0,20,8,0);
        addV(1,0,0,2, 65,0,20,8,0);
        addV(0,0,0,2, 65,1,22,4,0);
        addV(1,0,1,1, 32,0, 0,0,0);
        addV(1,0,0,1, 32,0, 0,0,0);
        addV(0,0,0,3, 32,0, 0,0,0);

        for (int i = 0; i < vq.size(); i++) begin
            applyStimulus(vq[i].play, vq[i].note_done, vq[i].reset_player, vq[i].song);
            checkOutput($sformatf("vec%0d_addr", i), {25'd0, rom_addr}, {25'd0, vq[i].addr});
            checkOutput($sformatf("vec%0d_nn", i), {31'd0, new_note}, {31'd0, vq[i].nn});
            checkOutput($sformatf("vec%0d_note", i), {26'd0, note}, {26'd0, vq[i].note});
            checkOutput($sformatf("vec%0d_dur", i), {26'd0, duration}, {26'd0, vq[i].dur});
            checkOutput($sformatf("vec%0d_sd", i), {31'd0, song_done}, {31'd0, vq[i].sd});
        end

        runSong(2'd3, $urandom_range(1, 31));
        runSong(2'd1, 32);
        runSong(2'd2, 0);
        runSong(2'd0, 32);

        // Async reset in the middle of a song clears everything without a clock edge.
        applyStimulus(1'b0, 1'b0, 1'b1, 2'd0);
        waitNewNote("async_nn1");
        applyStimulus(1'b1, 1'b1, 1'b0, 2'd0);
        waitNewNote("async_nn2");
        #2;
        reset = 1'b1;
        #1;
        checkOutput("async_addr", {25'd0, rom_addr}, 32'd0);
        checkOutput("async_note", {26'd0, note}, 32'd0);
        checkOutput("async_dur", {26'd0, duration}, 32'd0);
        checkOutput("async_nn", {31'd0, new_note}, 32'd0);
        checkOutput("async_sd", {31'd0, song_done}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 2'd2);
        checkOutput("post_reset_addr", {25'd0, rom_addr}, 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 2'd2);
        checkOutput("post_reset_play_addr", {25'd0, rom_addr}, 32'd64);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
